// File: rtl/track_zone_bbox.sv
// Per-zone bounding boxes of binary foreground pixels over NZONE equal vertical strips.
// Results are captured from the accumulators' next state so the frame-end pixel is included one clock later.
module track_zone_bbox #(
    parameter int IMG_HDISP = 1024,
    parameter int IMG_VDISP = 768,
    parameter int CW        = 11,
    parameter int NZONE     = 4,
    parameter int CNT_W     = 20,
    parameter int MIN_PIX   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   per_frame_vsync,
    input  logic                   per_frame_href,
    input  logic                   per_frame_clken,
    input  logic                   per_img_bit,
    output logic [NZONE*CW-1:0]    box_up,
    output logic [NZONE*CW-1:0]    box_down,
    output logic [NZONE*CW-1:0]    box_left,
    output logic [NZONE*CW-1:0]    box_right,
    output logic [NZONE*CNT_W-1:0] box_cnt,
    output logic [NZONE-1:0]       box_valid,
    output logic                   result_valid,
    output logic [15:0]            frame_cnt
);

    localparam int ZW  = IMG_HDISP / NZONE;
    localparam int ZIW = (NZONE > 1) ? $clog2(NZONE) : 1;
    localparam logic [CW-1:0]    X_LAST    = CW'(IMG_HDISP - 1);
    localparam logic [CW-1:0]    Y_LAST    = CW'(IMG_VDISP - 1);
    localparam logic [CW-1:0]    Y_DONE    = CW'(IMG_VDISP);
    localparam logic [CW-1:0]    UP_INIT   = CW'(IMG_VDISP);
    localparam logic [CW-1:0]    LEFT_INIT = CW'(IMG_HDISP);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   MIN_PIX_W = (CNT_W + 1)'(MIN_PIX);

    logic                 r_armed;
    logic [CW-1:0]        r_x_cnt;
    logic [CW-1:0]        r_y_cnt;
    logic [ZIW-1:0]       r_zone;

    logic [CW-1:0]        r_up    [NZONE];
    logic [CW-1:0]        r_down  [NZONE];
    logic [CW-1:0]        r_left  [NZONE];
    logic [CW-1:0]        r_right [NZONE];
    logic [CNT_W-1:0]     r_cnt   [NZONE];

    logic [CW-1:0]        w_up_nxt    [NZONE];
    logic [CW-1:0]        w_down_nxt  [NZONE];
    logic [CW-1:0]        w_left_nxt  [NZONE];
    logic [CW-1:0]        w_right_nxt [NZONE];
    logic [CNT_W-1:0]     w_cnt_nxt   [NZONE];
    logic [NZONE-1:0]     w_zone_valid;

    logic [CW-1:0]        r_box_up    [NZONE];
    logic [CW-1:0]        r_box_down  [NZONE];
    logic [CW-1:0]        r_box_left  [NZONE];
    logic [CW-1:0]        r_box_right [NZONE];
    logic [CNT_W-1:0]     r_box_cnt   [NZONE];
    logic [NZONE-1:0]     r_box_valid;
    logic                 r_result_valid;
    logic [15:0]          r_frame_cnt;

    logic w_accept;
    logic w_x_wrap;
    logic w_frame_end;
    logic w_zone_step;
    logic w_unused_href;

    assign w_unused_href = per_frame_href;

    // Pixels count only after a vsync has armed the frame and before the last line has completed.
    always_comb begin
        w_accept    = per_frame_clken && !per_frame_vsync && r_armed && (r_y_cnt < Y_DONE);
        w_x_wrap    = (r_x_cnt == X_LAST);
        w_frame_end = w_accept && w_x_wrap && (r_y_cnt == Y_LAST);
        w_zone_step = 1'b0;
        for (int k = 1; k < NZONE; k++) begin
            if (r_x_cnt == CW'(k * ZW - 1)) w_zone_step = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NZONE; k++) begin
            w_up_nxt[k]    = r_up[k];
            w_down_nxt[k]  = r_down[k];
            w_left_nxt[k]  = r_left[k];
            w_right_nxt[k] = r_right[k];
            w_cnt_nxt[k]   = r_cnt[k];
            if (w_accept && per_img_bit && (r_zone == ZIW'(k))) begin
                if (r_y_cnt < r_up[k])    w_up_nxt[k]    = r_y_cnt;
                if (r_y_cnt > r_down[k])  w_down_nxt[k]  = r_y_cnt;
                if (r_x_cnt < r_left[k])  w_left_nxt[k]  = r_x_cnt;
                if (r_x_cnt > r_right[k]) w_right_nxt[k] = r_x_cnt;
                if (r_cnt[k] != CNT_MAX)  w_cnt_nxt[k]   = r_cnt[k] + CNT_W'(1);
            end
            w_zone_valid[k] = ({1'b0, w_cnt_nxt[k]} >= MIN_PIX_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_zone  <= '0;
        end else if (per_frame_vsync) begin
            r_armed <= 1'b1;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_zone  <= '0;
        end else if (w_accept) begin
            if (w_x_wrap) begin
                r_x_cnt <= '0;
                r_zone  <= '0;
                r_y_cnt <= r_y_cnt + CW'(1);
            end else begin
                r_x_cnt <= r_x_cnt + CW'(1);
                if (w_zone_step) r_zone <= r_zone + ZIW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NZONE; k++) begin
                r_up[k]    <= UP_INIT;
                r_down[k]  <= '0;
                r_left[k]  <= LEFT_INIT;
                r_right[k] <= '0;
                r_cnt[k]   <= '0;
            end
        end else if (per_frame_vsync) begin
            for (int k = 0; k < NZONE; k++) begin
                r_up[k]    <= UP_INIT;
                r_down[k]  <= '0;
                r_left[k]  <= LEFT_INIT;
                r_right[k] <= '0;
                r_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NZONE; k++) begin
                r_up[k]    <= w_up_nxt[k];
                r_down[k]  <= w_down_nxt[k];
                r_left[k]  <= w_left_nxt[k];
                r_right[k] <= w_right_nxt[k];
                r_cnt[k]   <= w_cnt_nxt[k];
            end
        end
    end

    // Zones below MIN_PIX report a zero box but still expose their raw count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_valid <= 1'b0;
            r_frame_cnt    <= '0;
            r_box_valid    <= '0;
            for (int k = 0; k < NZONE; k++) begin
                r_box_up[k]    <= '0;
                r_box_down[k]  <= '0;
                r_box_left[k]  <= '0;
                r_box_right[k] <= '0;
                r_box_cnt[k]   <= '0;
            end
        end else begin
            r_result_valid <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_box_valid <= w_zone_valid;
                for (int k = 0; k < NZONE; k++) begin
                    r_box_up[k]    <= w_zone_valid[k] ? w_up_nxt[k]    : '0;
                    r_box_down[k]  <= w_zone_valid[k] ? w_down_nxt[k]  : '0;
                    r_box_left[k]  <= w_zone_valid[k] ? w_left_nxt[k]  : '0;
                    r_box_right[k] <= w_zone_valid[k] ? w_right_nxt[k] : '0;
                    r_box_cnt[k]   <= w_cnt_nxt[k];
                end
            end
        end
    end

    for (genvar g = 0; g < NZONE; g++) begin : g_pack
        assign box_up[g*CW +: CW]        = r_box_up[g];
        assign box_down[g*CW +: CW]      = r_box_down[g];
        assign box_left[g*CW +: CW]      = r_box_left[g];
        assign box_right[g*CW +: CW]     = r_box_right[g];
        assign box_cnt[g*CNT_W +: CNT_W] = r_box_cnt[g];
    end

    assign box_valid    = r_box_valid;
    assign result_valid = r_result_valid;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_track_zone_bbox.sv
// Bench for track_zone_bbox: two lockstep instances (8-bit and 4-bit counts) checked against a frame-level model.
`timescale 1ns/1ps
module tb_track_zone_bbox;

    localparam int H = 16, V = 8, NZ = 4, CW = 5, CNT_W = 8, CNT_W_S = 4, MIN_PIX = 2;
    localparam int ZW = H / NZ;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0, pix = 1'b0;

    logic [NZ*CW-1:0]      box_up, box_down, box_left, box_right;
    logic [NZ*CNT_W-1:0]   box_cnt;
    logic [NZ-1:0]         box_valid;
    logic                  result_valid;
    logic [15:0]           frame_cnt;

    logic [NZ*CW-1:0]      s_box_up, s_box_down, s_box_left, s_box_right;
    logic [NZ*CNT_W_S-1:0] s_box_cnt;
    logic [NZ-1:0]         s_box_valid;
    logic                  s_result_valid;
    logic [15:0]           s_frame_cnt;

    track_zone_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .CW(CW), .NZONE(NZ), .CNT_W(CNT_W), .MIN_PIX(MIN_PIX)) dut (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_bit(pix),
        .box_up(box_up), .box_down(box_down), .box_left(box_left), .box_right(box_right),
        .box_cnt(box_cnt), .box_valid(box_valid), .result_valid(result_valid), .frame_cnt(frame_cnt)
    );

    track_zone_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .CW(CW), .NZONE(NZ), .CNT_W(CNT_W_S), .MIN_PIX(MIN_PIX)) dut_sat (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_bit(pix),
        .box_up(s_box_up), .box_down(s_box_down), .box_left(s_box_left), .box_right(s_box_right),
        .box_cnt(s_box_cnt), .box_valid(s_box_valid), .result_valid(s_result_valid), .frame_cnt(s_frame_cnt)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]           cyc;
        logic [15:0]           fcnt;
        logic [NZ*CW-1:0]      up;
        logic [NZ*CW-1:0]      down;
        logic [NZ*CW-1:0]      left;
        logic [NZ*CW-1:0]      right;
        logic [NZ*CNT_W-1:0]   cnt;
        logic [NZ*CNT_W_S-1:0] cnt_s;
        logic [NZ-1:0]         valid;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   model_fcnt = 0;
    int   last_pix_cyc = 0;
    int   tests = 0, errors = 0;
    bit   use_gaps = 1'b0;
    bit   fg [V][H];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: bounding box per strip straight from the pixel map.
    function automatic exp_t model_frame();
        exp_t e;
        int c, u, d, l, r;
        e = '0;
        for (int k = 0; k < NZ; k++) begin
            c = 0; u = V; d = 0; l = H; r = 0;
            for (int y = 0; y < V; y++)
                for (int x = k * ZW; x < (k + 1) * ZW; x++)
                    if (fg[y][x]) begin
                        c++;
                        if (y < u) u = y;
                        if (y > d) d = y;
                        if (x < l) l = x;
                        if (x > r) r = x;
                    end
            e.cnt[k*CNT_W +: CNT_W]       = CNT_W'((c > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : c);
            e.cnt_s[k*CNT_W_S +: CNT_W_S] = CNT_W_S'((c > (1 << CNT_W_S) - 1) ? (1 << CNT_W_S) - 1 : c);
            if (c >= MIN_PIX) begin
                e.valid[k]          = 1'b1;
                e.up[k*CW +: CW]    = CW'(u);
                e.down[k*CW +: CW]  = CW'(d);
                e.left[k*CW +: CW]  = CW'(l);
                e.right[k*CW +: CW] = CW'(r);
            end
        end
        return e;
    endfunction

    function automatic void check_outputs(input string tag, input exp_t e);
        check({tag, "_up"},     64'(box_up),    64'(e.up));
        check({tag, "_down"},   64'(box_down),  64'(e.down));
        check({tag, "_left"},   64'(box_left),  64'(e.left));
        check({tag, "_right"},  64'(box_right), 64'(e.right));
        check({tag, "_cnt"},    64'(box_cnt),   64'(e.cnt));
        check({tag, "_valid"},  64'(box_valid), 64'(e.valid));
        check({tag, "_fcnt"},   64'(frame_cnt), 64'(e.fcnt));
        check({tag, "_cnt_sat"}, 64'(s_box_cnt), 64'(e.cnt_s));
    endfunction

    // Scoreboard monitor
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid) begin
            check("single_cycle_pulse", 64'(prev_rv), 64'(0));
            check("sat_pulse_lockstep", 64'(s_result_valid), 64'(1));
            check("pulse_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check_outputs("frame", e);
            end
        end
        prev_rv = result_valid;
    end

    // Driver tasks
    task automatic step(input logic vs, input logic ce, input logic b);
        @(posedge clk);
        #1;
        vsync = vs;
        clken = ce;
        href  = ce;
        pix   = b;
    endtask

    task automatic vsync_pulse();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixels(input int npix, input bit vs_last);
        for (int i = 0; i < npix; i++) begin
            if (use_gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(vs_last && (i == npix - 1), 1'b1, fg[i / H][i % H]);
            last_pix_cyc = cyc;
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int dens);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                fg[y][x] = ($urandom_range(0, 99) < dens);
    endtask

    task automatic run_frame();
        exp_t e;
        vsync_pulse();
        send_pixels(H * V, 1'b0);
        e = model_frame();
        model_fcnt++;
        e.fcnt = 16'(model_fcnt);
        e.cyc  = 32'(last_pix_cyc + 1);
        exp_q.push_back(e);
        last_exp = e;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fcnt",  64'(frame_cnt),    64'(0));
        check("rst_rv",    64'(result_valid), 64'(0));
        check("rst_valid", 64'(box_valid),    64'(0));
        check("rst_up",    64'(box_up),       64'(0));
        check("rst_cnt",   64'(box_cnt),      64'(0));
        rst_n = 1'b1;

        // A frame before any vsync is not counted
        fill(50);
        send_pixels(H * V, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("no_vsync_fcnt", 64'(frame_cnt), 64'(0));

        // Three diagonal pixels inside zone 1
        fill(0);
        fg[2][5] = 1'b1; fg[3][6] = 1'b1; fg[4][7] = 1'b1;
        run_frame();
        check("diag_up",    64'(box_up[9:5]),     64'(2));
        check("diag_down",  64'(box_down[9:5]),   64'(4));
        check("diag_left",  64'(box_left[9:5]),   64'(5));
        check("diag_right", 64'(box_right[9:5]),  64'(7));
        check("diag_cnt",   64'(box_cnt[15:8]),   64'(3));
        check("diag_valid", 64'(box_valid),       64'(4'b0010));
        check("diag_z0_up", 64'(box_up[4:0]),     64'(0));

        // Single pixel in zone 3 stays below MIN_PIX
        fill(0);
        fg[1][12] = 1'b1;
        run_frame();
        check("single_cnt",   64'(box_cnt[31:24]),    64'(1));
        check("single_valid", 64'(box_valid[3]),      64'(0));
        check("single_right", 64'(box_right[19:15]),  64'(0));

        // Zone boundary split between x=3 and x=4
        fill(0);
        fg[0][3] = 1'b1; fg[0][4] = 1'b1;
        run_frame();
        check("split_z0", 64'(box_cnt[7:0]),  64'(1));
        check("split_z1", 64'(box_cnt[15:8]), 64'(1));

        // Pixels after the frame end are ignored and never start a new frame
        for (int i = 0; i < H * V + 4; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs("post_end", last_exp);

        // Full foreground saturates the narrow counters
        fill(100);
        run_frame();
        check("full_cnt8",  64'(box_cnt[7:0]),  64'(32));
        check("full_cnt4",  64'(s_box_cnt[3:0]), 64'(15));

        // Vsync at pixel 50 aborts the frame
        fill(40);
        vsync_pulse();
        send_pixels(50, 1'b0);
        vsync_pulse();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("abort", last_exp);
        run_frame();

        // Vsync coinciding with the frame-end pixel wins
        fill(60);
        vsync_pulse();
        send_pixels(H * V, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_outputs("collide", last_exp);

        // Random frames with idle gaps
        use_gaps = 1'b1;
        for (int f = 0; f < 8; f++) begin
            fill($urandom_range(0, 4) * 25);
            run_frame();
        end

        // Reset mid-frame clears outputs asynchronously
        fill(50);
        run_frame();
        vsync_pulse();
        send_pixels(60, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_fcnt",  64'(frame_cnt),  64'(0));
        check("arst_valid", 64'(box_valid),  64'(0));
        check("arst_cnt",   64'(box_cnt),    64'(0));
        check("arst_right", 64'(box_right),  64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_fcnt = 0;
        last_exp = '0;
        fill(30);
        run_frame();
        check("post_rst_fcnt", 64'(frame_cnt), 64'(1));

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/track_zone_bbox.md
TRACK_ZONE_BBOX -- requirements
Module: track_zone_bbox

Interface
REQ-001 The block SHALL have parameter IMG_HDISP, default 1024, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMG_VDISP, default 768, meaning active lines per frame.
REQ-003 The block SHALL have parameter CW, default 11, meaning coordinate width.
REQ-004 The block SHALL have parameter NZONE, default 4, meaning number of equal vertical strips; IMG_HDISP SHALL be a multiple of NZONE.
REQ-005 The block SHALL have parameter CNT_W, default 20, meaning per-zone pixel-count width.
REQ-006 The block SHALL have parameter MIN_PIX, default 64, meaning the minimum foreground pixel count for a zone result to be valid.
REQ-007 Port clk, input, 1 bit: clock.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port per_frame_vsync, input, 1 bit: high means inter-frame blanking; clears the frame state.
REQ-010 Port per_frame_href, input, 1 bit: line active; informational only, not used for gating.
REQ-011 Port per_frame_clken, input, 1 bit: pixel strobe; one pixel is accepted per high cycle.
REQ-012 Port per_img_bit, input, 1 bit: binary foreground flag of the accepted pixel.
REQ-013 Ports box_up, box_down, box_left, box_right, output, NZONE*CW bits each: per-zone box edges; zone k occupies slice [k*CW +: CW].
REQ-014 Port box_cnt, output, NZONE*CNT_W bits: per-zone foreground pixel count.
REQ-015 Port box_valid, output, NZONE bits: per-zone result-valid flag.
REQ-016 Port result_valid, output, 1 bit: single-cycle pulse marking new results.
REQ-017 Port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-018 x_cnt/y_cnt SHALL reset to 0 while vsync is high; on each clken, x_cnt SHALL increment and wrap to 0 at IMG_HDISP-1, and y_cnt SHALL then increment.
REQ-019 A zone index register SHALL track x_cnt sequentially (no divider): reset to 0 at x_cnt wrap, incremented when x_cnt reaches k*(IMG_HDISP/NZONE)-1.
REQ-020 Per-zone accumulators SHALL reset on vsync: up=IMG_VDISP, down=0, left=IMG_HDISP, right=0, cnt=0.
REQ-021 On clken with per_img_bit=1, only the current zone's accumulators SHALL update: min/max of y_cnt for up/down, min/max of absolute x_cnt for left/right, cnt+1.
REQ-022 cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Once y_cnt reaches IMG_VDISP, further clken pulses SHALL be ignored until the next vsync, with no counter wrap.
REQ-024 The frame end SHALL be the accepted clken at x_cnt=IMG_HDISP-1, y_cnt=IMG_VDISP-1; that pixel SHALL be included in the results.
REQ-025 The cycle after the frame end, all output registers SHALL load, result_valid SHALL pulse high for exactly 1 cycle, and frame_cnt SHALL increment, wrapping at 0xFFFF.
REQ-026 box_valid[k] SHALL be 1 iff cnt_k>=MIN_PIX; if box_valid[k]=0, zone k's up/down/left/right SHALL output 0 while box_cnt still outputs the raw count.
REQ-027 Vsync asserted mid-frame SHALL abort the frame: accumulators clear, outputs hold their previous values, and no result_valid pulse is generated.
REQ-028 Vsync and the frame-end clken arriving in the same cycle: vsync SHALL win, with no capture and no pulse.
REQ-029 Outputs SHALL hold their values between result_valid pulses.

Reset
REQ-030 On rst_n low, all outputs, counters, and frame_cnt SHALL go to 0 immediately; accumulators SHALL take their REQ-020 values.
REQ-031 After rst_n is released, the block SHALL require a vsync before the first frame is counted.
REQ-032 Reset asserted mid-frame SHALL discard that frame.

Verification
(bench parameters: H=16, V=8, NZONE=4, CW=5, CNT_W=8, MIN_PIX=2)
REQ-033 Scenario: foreground at (x,y)=(5,2), (6,3), (7,4) -> zone1 reports up=2, down=4, left=5, right=7, cnt=3, valid=1; other zones report valid=0, box=0; result_valid is 1 cycle, 1 clk after the last pixel.
REQ-034 Scenario: single pixel at (12,1) -> zone3 reports cnt=1, valid=0, box=0.
REQ-035 Scenario: pixels at x=3 and x=4 on line 0 -> zone0 reports cnt=1 and zone1 reports cnt=1, confirming zone-boundary split.
REQ-036 Scenario: full-foreground frame with CNT_W=4 -> each zone's cnt saturates at 15.
REQ-037 Scenario: vsync at pixel 50 -> no pulse, outputs and frame_cnt unchanged; next full frame gives correct results.
REQ-038 Scenario: rst_n low mid-frame -> outputs are 0 asynchronously; after vsync and one frame, frame_cnt=1.
